// File: rtl/param_controller_pkg.sv
// Shared definitions for the venera_cpu instruction controller: opcodes, ALU
// codes and controller state encodings.
package param_controller_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_JUMP   = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_UNLOAD = 8'h03;
    localparam logic [7:0] OP_ADD    = 8'h04;
    localparam logic [7:0] OP_SUB    = 8'h05;
    localparam logic [7:0] OP_JZ     = 8'h06;
    localparam logic [7:0] OP_ADDM   = 8'h07;
    localparam logic [7:0] OP_SUBM   = 8'h08;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_ISSUE = 2'd1,
        S_RD_WAIT  = 2'd2,
        S_RESULT   = 2'd3
    } state_e;

    // Which memory-operand instruction is waiting for its read data.
    typedef enum logic [1:0] {
        MOP_LOAD = 2'd0,
        MOP_ADDM = 2'd1,
        MOP_SUBM = 2'd2
    } mem_op_e;

    function automatic logic [2:0] mem_op_alu_code(input mem_op_e op);
        return (op == MOP_SUBM) ? ALU_SUB : ALU_ADD;
    endfunction

endpackage

// File: rtl/param_controller_rd_seq.sv
// Memory read sequencer: issues the read strobe, counts out the read latency and
// presents the returned data together with a one-cycle done pulse.
module param_controller_rd_seq
    import param_controller_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_address,
    output logic              done,
    output logic [DATA_W-1:0] data
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic              mem_rd_r;
    logic [ADDR_W-1:0] mem_address_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              done_s;

    // Read strobe and address: the cycle after start is the issue cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mem_rd_r      <= 1'b0;
            mem_address_r <= {ADDR_W{1'b0}};
        end else begin
            mem_rd_r      <= start;
            mem_address_r <= start ? address : {ADDR_W{1'b0}};
        end
    end

    // Latency counter: loaded during the issue cycle, last wait cycle is at one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (mem_rd_r) begin
            wait_cnt_r <= CNT_LAT;
        end else if (wait_cnt_r != CNT_ZERO) begin
            wait_cnt_r <= wait_cnt_r - CNT_ONE;
        end else begin
            wait_cnt_r <= CNT_ZERO;
        end
    end

    assign done_s      = (wait_cnt_r == CNT_ONE);
    assign done        = done_s;
    assign data        = done_s ? mem_data : {DATA_W{1'b0}};
    assign mem_rd      = mem_rd_r;
    assign mem_address = mem_address_r;

endmodule

// File: rtl/param_controller.sv
// Instruction controller: decodes one {opcode, operand} per handshake and drives
// jump, memory, accumulator and ALU strobes as registered one-cycle pulses.
module param_controller
    import param_controller_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int OPCODE_W   = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_instruction_valid,
    output logic                       o_instruction_ready,
    input  logic [OPCODE_W+ADDR_W-1:0] i_instruction,
    output logic                       o_valid_set_address_instruction,
    output logic [ADDR_W-1:0]          o_value_set_address_instruction,
    output logic                       o_mem_rd,
    output logic [ADDR_W-1:0]          o_mem_address_rd,
    input  logic [DATA_W-1:0]          i_mem_data_rd,
    output logic                       o_mem_wr,
    output logic [ADDR_W-1:0]          o_mem_address_wr,
    output logic [DATA_W-1:0]          o_mem_data_wr,
    output logic                       o_load_to_accumulator_valid,
    output logic [DATA_W-1:0]          o_load_to_accumulator_data,
    output logic [2:0]                 o_alu_control,
    output logic                       o_alu_load,
    output logic [DATA_W-1:0]          o_alu_data,
    input  logic [DATA_W-1:0]          i_current_accum_value,
    output logic                       o_illegal_opcode
);

    localparam int INSTR_W = OPCODE_W + ADDR_W;
    localparam logic [OPCODE_W-1:0] OPC_NOP    = OPCODE_W'(OP_NOP);
    localparam logic [OPCODE_W-1:0] OPC_JUMP   = OPCODE_W'(OP_JUMP);
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = OPCODE_W'(OP_LOAD);
    localparam logic [OPCODE_W-1:0] OPC_UNLOAD = OPCODE_W'(OP_UNLOAD);
    localparam logic [OPCODE_W-1:0] OPC_ADD    = OPCODE_W'(OP_ADD);
    localparam logic [OPCODE_W-1:0] OPC_SUB    = OPCODE_W'(OP_SUB);
    localparam logic [OPCODE_W-1:0] OPC_JZ     = OPCODE_W'(OP_JZ);
    localparam logic [OPCODE_W-1:0] OPC_ADDM   = OPCODE_W'(OP_ADDM);
    localparam logic [OPCODE_W-1:0] OPC_SUBM   = OPCODE_W'(OP_SUBM);

    state_e              state_r, state_s;
    mem_op_e             mem_op_r, mem_op_s;
    logic                ready_r;
    logic                accept_s;
    logic [OPCODE_W-1:0] opcode_s;
    logic [ADDR_W-1:0]   operand_s;

    logic              jump_v_r, jump_v_s;
    logic [ADDR_W-1:0] jump_a_r, jump_a_s;
    logic              wr_r, wr_s;
    logic [ADDR_W-1:0] wr_a_r, wr_a_s;
    logic [DATA_W-1:0] wr_d_r, wr_d_s;
    logic              acc_v_r, acc_v_s;
    logic [DATA_W-1:0] acc_d_r, acc_d_s;
    logic [2:0]        alu_ctrl_r, alu_ctrl_s;
    logic              alu_load_r, alu_load_s;
    logic [DATA_W-1:0] alu_data_r, alu_data_s;
    logic              illegal_r, illegal_s;

    logic              rd_start_s;
    logic              rd_done_s;
    logic [DATA_W-1:0] rd_data_s;

    assign opcode_s  = i_instruction[INSTR_W-1:ADDR_W];
    assign operand_s = i_instruction[ADDR_W-1:0];
    assign accept_s  = i_instruction_valid && ready_r;

    param_controller_rd_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_seq (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .start      (rd_start_s),
        .address    (operand_s),
        .mem_data   (i_mem_data_rd),
        .mem_rd     (o_mem_rd),
        .mem_address(o_mem_address_rd),
        .done       (rd_done_s),
        .data       (rd_data_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_s    = state_r;
        mem_op_s   = mem_op_r;
        rd_start_s = 1'b0;
        jump_v_s   = 1'b0;
        jump_a_s   = {ADDR_W{1'b0}};
        wr_s       = 1'b0;
        wr_a_s     = {ADDR_W{1'b0}};
        wr_d_s     = {DATA_W{1'b0}};
        acc_v_s    = 1'b0;
        acc_d_s    = {DATA_W{1'b0}};
        alu_ctrl_s = alu_ctrl_r;
        alu_load_s = 1'b0;
        alu_data_s = {DATA_W{1'b0}};
        illegal_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    case (opcode_s)
                        OPC_NOP: state_s = S_IDLE;
                        OPC_JUMP: begin
                            jump_v_s = 1'b1;
                            jump_a_s = operand_s;
                        end
                        OPC_JZ: begin
                            if (i_current_accum_value == {DATA_W{1'b0}}) begin
                                jump_v_s = 1'b1;
                                jump_a_s = operand_s;
                            end else begin
                                jump_v_s = 1'b0;
                            end
                        end
                        OPC_UNLOAD: begin
                            wr_s   = 1'b1;
                            wr_a_s = operand_s;
                            wr_d_s = i_current_accum_value;
                        end
                        OPC_ADD, OPC_SUB: begin
                            alu_load_s = 1'b1;
                            alu_data_s = DATA_W'(operand_s);
                            alu_ctrl_s = (opcode_s == OPC_SUB) ? ALU_SUB : ALU_ADD;
                            state_s    = S_RESULT;
                        end
                        OPC_LOAD: begin
                            rd_start_s = 1'b1;
                            mem_op_s   = MOP_LOAD;
                            state_s    = S_RD_ISSUE;
                        end
                        OPC_ADDM: begin
                            rd_start_s = 1'b1;
                            mem_op_s   = MOP_ADDM;
                            state_s    = S_RD_ISSUE;
                        end
                        OPC_SUBM: begin
                            rd_start_s = 1'b1;
                            mem_op_s   = MOP_SUBM;
                            state_s    = S_RD_ISSUE;
                        end
                        default: illegal_s = 1'b1;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_ISSUE: state_s = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rd_done_s) begin
                    state_s = S_RESULT;
                    if (mem_op_r == MOP_LOAD) begin
                        acc_v_s = 1'b1;
                        acc_d_s = rd_data_s;
                    end else begin
                        alu_load_s = 1'b1;
                        alu_data_s = rd_data_s;
                        alu_ctrl_s = mem_op_alu_code(mem_op_r);
                    end
                end else begin
                    state_s = S_RD_WAIT;
                end
            end
            S_RESULT: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State and registered outputs; ready reflects the state being entered.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= S_IDLE;
            mem_op_r   <= MOP_LOAD;
            ready_r    <= 1'b0;
            jump_v_r   <= 1'b0;
            jump_a_r   <= {ADDR_W{1'b0}};
            wr_r       <= 1'b0;
            wr_a_r     <= {ADDR_W{1'b0}};
            wr_d_r     <= {DATA_W{1'b0}};
            acc_v_r    <= 1'b0;
            acc_d_r    <= {DATA_W{1'b0}};
            alu_ctrl_r <= ALU_NONE;
            alu_load_r <= 1'b0;
            alu_data_r <= {DATA_W{1'b0}};
            illegal_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            mem_op_r   <= mem_op_s;
            ready_r    <= (state_s == S_IDLE);
            jump_v_r   <= jump_v_s;
            jump_a_r   <= jump_a_s;
            wr_r       <= wr_s;
            wr_a_r     <= wr_a_s;
            wr_d_r     <= wr_d_s;
            acc_v_r    <= acc_v_s;
            acc_d_r    <= acc_d_s;
            alu_ctrl_r <= alu_ctrl_s;
            alu_load_r <= alu_load_s;
            alu_data_r <= alu_data_s;
            illegal_r  <= illegal_s;
        end
    end

    assign o_instruction_ready             = ready_r;
    assign o_valid_set_address_instruction = jump_v_r;
    assign o_value_set_address_instruction = jump_a_r;
    assign o_mem_wr                        = wr_r;
    assign o_mem_address_wr                = wr_a_r;
    assign o_mem_data_wr                   = wr_d_r;
    assign o_load_to_accumulator_valid     = acc_v_r;
    assign o_load_to_accumulator_data      = acc_d_r;
    assign o_alu_control                   = alu_ctrl_r;
    assign o_alu_load                      = alu_load_r;
    assign o_alu_data                      = alu_data_r;
    assign o_illegal_opcode                = illegal_r;

endmodule

// File: tb/tb_param_controller.sv
// Bench for param_controller: cycle-indexed expectation table filled from the
// instruction-level timing rules, compared against the DUT every cycle.
module tb_param_controller;
    import param_controller_pkg::*;

    localparam int DW   = 16;
    localparam int LAT  = 3;
    localparam int NCYC = 400;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        i_reset_n;
    logic        i_instruction_valid;
    logic [15:0] i_instruction;
    logic [15:0] i_mem_data_rd;
    logic [15:0] i_current_accum_value;
    logic        o_instruction_ready, o_valid_set_address_instruction, o_mem_rd, o_mem_wr;
    logic [7:0]  o_value_set_address_instruction, o_mem_address_rd, o_mem_address_wr;
    logic [15:0] o_mem_data_wr, o_load_to_accumulator_data, o_alu_data;
    logic        o_load_to_accumulator_valid, o_alu_load, o_illegal_opcode;
    logic [2:0]  o_alu_control;

    param_controller #(.DATA_W(DW), .ADDR_W(8), .OPCODE_W(8), .RD_LATENCY(LAT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_instruction_valid(i_instruction_valid), .o_instruction_ready(o_instruction_ready),
        .i_instruction(i_instruction),
        .o_valid_set_address_instruction(o_valid_set_address_instruction),
        .o_value_set_address_instruction(o_value_set_address_instruction),
        .o_mem_rd(o_mem_rd), .o_mem_address_rd(o_mem_address_rd), .i_mem_data_rd(i_mem_data_rd),
        .o_mem_wr(o_mem_wr), .o_mem_address_wr(o_mem_address_wr), .o_mem_data_wr(o_mem_data_wr),
        .o_load_to_accumulator_valid(o_load_to_accumulator_valid),
        .o_load_to_accumulator_data(o_load_to_accumulator_data),
        .o_alu_control(o_alu_control), .o_alu_load(o_alu_load), .o_alu_data(o_alu_data),
        .i_current_accum_value(i_current_accum_value), .o_illegal_opcode(o_illegal_opcode)
    );

    // Second instance: 8-bit data, single-cycle read latency.
    logic        v1, rdy1, jv1, rd1, wr1, av1, al1, ill1;
    logic [15:0] instr1;
    logic [7:0]  mem1, acc1, ja1, ra1, wa1, wd1, ad1, ld1;
    logic [2:0]  ctl1;

    param_controller #(.DATA_W(8), .ADDR_W(8), .OPCODE_W(8), .RD_LATENCY(1)) dut1 (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_instruction_valid(v1), .o_instruction_ready(rdy1), .i_instruction(instr1),
        .o_valid_set_address_instruction(jv1), .o_value_set_address_instruction(ja1),
        .o_mem_rd(rd1), .o_mem_address_rd(ra1), .i_mem_data_rd(mem1),
        .o_mem_wr(wr1), .o_mem_address_wr(wa1), .o_mem_data_wr(wd1),
        .o_load_to_accumulator_valid(av1), .o_load_to_accumulator_data(ad1),
        .o_alu_control(ctl1), .o_alu_load(al1), .o_alu_data(ld1),
        .i_current_accum_value(acc1), .o_illegal_opcode(ill1)
    );

    typedef struct packed {
        logic        rdy;
        logic        jv;
        logic [7:0]  ja;
        logic        rd;
        logic [7:0]  ra;
        logic        wr;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic        av;
        logic [15:0] ad;
        logic        al;
        logic [15:0] ld;
        logic [2:0]  ctrl;
        logic        ill;
    } exp_t;

    exp_t        exp_q [NCYC];
    logic        mem_v [NCYC];
    logic [15:0] mem_d [NCYC];
    exp_t        cmp_e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          last_a = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, act, want);
        end
    endtask

    // Reset from cycle 'from' aborts everything; ready returns the cycle after 'rel'.
    task automatic rst_model(input int from, input int rel);
        for (int k = from; k < NCYC; k++) begin
            exp_q[k]     = '0;
            exp_q[k].rdy = (k > rel);
        end
    endtask

    task automatic set_ctrl(input int k, input logic [2:0] code);
        for (int j = k; j < NCYC; j++) exp_q[j].ctrl = code;
    endtask

    // Instruction-level timing rules: what an instruction accepted in cycle a produces.
    task automatic predict(input logic [7:0] op, input logic [7:0] opd,
                           input logic [15:0] acc, input logic [15:0] md, input int a);
        int r;
        r = a + 2 + LAT;
        case (op)
            OP_NOP: ;
            OP_JUMP: begin exp_q[a+1].jv = 1'b1; exp_q[a+1].ja = opd; end
            OP_JZ: if (acc == 16'h0000) begin exp_q[a+1].jv = 1'b1; exp_q[a+1].ja = opd; end
            OP_UNLOAD: begin
                exp_q[a+1].wr = 1'b1; exp_q[a+1].wa = opd; exp_q[a+1].wd = acc;
            end
            OP_ADD, OP_SUB: begin
                exp_q[a+1].al  = 1'b1;
                exp_q[a+1].ld  = {8'h00, opd};
                exp_q[a+1].rdy = 1'b0;
                set_ctrl(a + 1, (op == OP_SUB) ? 3'b010 : 3'b001);
            end
            OP_LOAD, OP_ADDM, OP_SUBM: begin
                exp_q[a+1].rd = 1'b1; exp_q[a+1].ra = opd;
                mem_v[a+1+LAT] = 1'b1; mem_d[a+1+LAT] = md;
                for (int k = a + 1; k <= r; k++) exp_q[k].rdy = 1'b0;
                if (op == OP_LOAD) begin
                    exp_q[r].av = 1'b1; exp_q[r].ad = md;
                end else begin
                    exp_q[r].al = 1'b1; exp_q[r].ld = md;
                    set_ctrl(r, (op == OP_SUBM) ? 3'b010 : 3'b001);
                end
            end
            default: exp_q[a+1].ill = 1'b1;
        endcase
    endtask

    // Advance to the next negedge and drive idle/junk inputs for that cycle.
    task automatic tick();
        @(negedge i_clk);
        i_instruction_valid   = 1'b0;
        i_instruction         = 16'h5AA5;
        i_current_accum_value = 16'hC3C3;
        i_mem_data_rd         = mem_v[cyc] ? mem_d[cyc] : 16'hDEAD;
        v1     = 1'b0;
        instr1 = 16'h5AA5;
        acc1   = 8'h3C;
        mem1   = 8'hA5;
    endtask

    // Present an instruction, holding it while the model says the DUT is busy.
    task automatic issue(input logic [7:0] op, input logic [7:0] opd,
                         input logic [15:0] acc, input logic [15:0] md);
        int guard;
        guard = 0;
        i_instruction_valid = 1'b1;
        i_instruction       = {op, opd};
        while (!exp_q[cyc].rdy && guard < 50) begin
            tick();
            i_instruction_valid = 1'b1;
            i_instruction       = {op, opd};
            guard++;
        end
        chk("issue_wait_bound", 32'(guard < 50), 32'd1);
        i_current_accum_value = acc;
        last_a = cyc;
        predict(op, opd, acc, md, cyc);
        tick();
    endtask

    // Per-cycle comparison of every DUT output against the expectation table.
    always @(negedge i_clk) begin
        if (cyc > 0 && cyc < NCYC) begin
            cmp_e = exp_q[cyc];
            chk("ready",     32'(o_instruction_ready),             32'(cmp_e.rdy));
            chk("jump_v",    32'(o_valid_set_address_instruction), 32'(cmp_e.jv));
            chk("jump_addr", 32'(o_value_set_address_instruction), 32'(cmp_e.ja));
            chk("mem_rd",    32'(o_mem_rd),                        32'(cmp_e.rd));
            chk("rd_addr",   32'(o_mem_address_rd),                32'(cmp_e.ra));
            chk("mem_wr",    32'(o_mem_wr),                        32'(cmp_e.wr));
            chk("wr_addr",   32'(o_mem_address_wr),                32'(cmp_e.wa));
            chk("wr_data",   32'(o_mem_data_wr),                   32'(cmp_e.wd));
            chk("acc_v",     32'(o_load_to_accumulator_valid),     32'(cmp_e.av));
            chk("acc_data",  32'(o_load_to_accumulator_data),      32'(cmp_e.ad));
            chk("alu_load",  32'(o_alu_load),                      32'(cmp_e.al));
            chk("alu_data",  32'(o_alu_data),                      32'(cmp_e.ld));
            chk("alu_ctrl",  32'(o_alu_control),                   32'(cmp_e.ctrl));
            chk("illegal",   32'(o_illegal_opcode),                32'(cmp_e.ill));
        end
    end

    initial begin
        int a1;
        for (int k = 0; k < NCYC; k++) begin
            exp_q[k] = '0;
            exp_q[k].rdy = 1'b1;
            mem_v[k] = 1'b0;
            mem_d[k] = 16'h0000;
        end
        rst_model(0, 3);
        i_reset_n = 1'b0;
        i_instruction_valid = 1'b1;
        i_instruction = {OP_JUMP, 8'h20};
        i_current_accum_value = 16'hC3C3;
        i_mem_data_rd = 16'hDEAD;
        v1 = 1'b0; instr1 = 16'h5AA5; acc1 = 8'h3C; mem1 = 8'hA5;

        // Reset held with a JUMP presented; released in cycle 3.
        tick(); i_instruction_valid = 1'b1; i_instruction = {OP_JUMP, 8'h20};
        tick(); i_instruction_valid = 1'b1; i_instruction = {OP_JUMP, 8'h20};
        tick(); i_instruction_valid = 1'b1; i_instruction = {OP_JUMP, 8'h20}; i_reset_n = 1'b1;
        tick();

        issue(OP_JUMP,   8'h3C, 16'hC3C3, 16'h0000);
        issue(OP_UNLOAD, 8'h10, 16'h00A5, 16'h0000);
        chk("pin_unload_data", 32'(exp_q[last_a+1].wd), 32'h0000_00A5);
        tick();

        issue(OP_LOAD, 8'h07, 16'hC3C3, 16'h005A);
        chk("pin_load_valid", 32'(exp_q[last_a+5].av), 32'd1);
        chk("pin_load_data",  32'(exp_q[last_a+5].ad), 32'h0000_005A);
        chk("pin_load_busy",  32'(exp_q[last_a+5].rdy), 32'd0);
        chk("pin_load_free",  32'(exp_q[last_a+6].rdy), 32'd1);

        issue(OP_JZ, 8'h44, 16'h0000, 16'h0000);
        issue(OP_JZ, 8'h45, 16'h0001, 16'h0000);
        chk("pin_jz_nonzero", 32'(exp_q[last_a+1].jv), 32'd0);

        issue(OP_ADDM, 8'h02, 16'hC3C3, 16'h0011);
        issue(OP_SUB,  8'hFF, 16'hC3C3, 16'h0000);
        chk("pin_sub_data", 32'(exp_q[last_a+1].ld),   32'h0000_00FF);
        chk("pin_sub_ctrl", 32'(exp_q[last_a+1].ctrl), 32'd2);

        issue(OP_ADD,    8'h83, 16'hC3C3, 16'h0000);
        issue(OP_UNLOAD, 8'h21, 16'h1234, 16'h0000);
        issue(8'hEE,     8'h12, 16'hC3C3, 16'h0000);
        issue(OP_NOP,    8'h34, 16'hC3C3, 16'h0000);
        issue(OP_SUBM,   8'h09, 16'hC3C3, 16'hF00D);
        tick();

        // Reset asserted during the read wait of a LOAD.
        issue(OP_LOAD, 8'h30, 16'hC3C3, 16'h0077);
        tick();
        tick();
        #2 i_reset_n = 1'b0;
        rst_model(cyc + 1, cyc + 3);
        tick();
        tick();
        tick(); i_reset_n = 1'b1;
        tick();
        issue(OP_JUMP, 8'h55, 16'hC3C3, 16'h0000);
        tick();

        // LOAD on the single-latency instance with literal expectations.
        a1 = cyc;
        v1 = 1'b1; instr1 = {OP_LOAD, 8'h07};
        tick();
        chk("l1_rd",       32'(rd1),  32'd1);
        chk("l1_rd_addr",  32'(ra1),  32'h07);
        chk("l1_ready_a1", 32'(rdy1), 32'd0);
        tick(); mem1 = 8'h5A;
        chk("l1_ready_a2", 32'(rdy1), 32'd0);
        chk("l1_rd_done",  32'(rd1),  32'd0);
        tick();
        chk("l1_acc_v",    32'(av1),  32'd1);
        chk("l1_acc_data", 32'(ad1),  32'h5A);
        chk("l1_ready_a3", 32'(rdy1), 32'd0);
        chk("l1_cycle",    32'(cyc - a1), 32'd3);
        tick();
        chk("l1_ready_a4", 32'(rdy1), 32'd1);
        chk("l1_acc_off",  32'(av1),  32'd0);

        tick();
        tick();
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/param_controller.md
# param_controller

Parametrised instruction controller for venera_cpu, successor to the fixed 8-bit controller. Sits between the instruction fetch unit and the data memory, accumulator and ALU. It decodes one instruction per handshake and drives jump, memory read/write, accumulator-load and ALU-load pulses. Additions over the previous generation:
- parametrised widths and memory read latency;
- ready/valid back-pressure;
- conditional jump (JZ) and memory-operand arithmetic (ADDM/SUBM);
- illegal-opcode flagging.

## Interface
Parameters:
- DATA_W, 8, accumulator/memory data width (4..32)
- ADDR_W, 8, memory/instruction address width; also operand field width (4..16)
- OPCODE_W, 8, opcode field width
- RD_LATENCY, 1, cycles from o_mem_rd pulse to valid i_mem_data_rd (1..4)

Ports:
- i_clk  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_instruction_valid  in  1  instruction present
- o_instruction_ready  out  1  controller can accept
- i_instruction  in  OPCODE_W+ADDR_W  {opcode, operand}
- o_valid_set_address_instruction  out  1  jump pulse
- o_value_set_address_instruction  out  ADDR_W  jump target
- o_mem_rd  out  1  read pulse
- o_mem_address_rd  out  ADDR_W  read address
- i_mem_data_rd  in  DATA_W  read data
- o_mem_wr  out  1  write pulse
- o_mem_address_wr  out  ADDR_W  write address
- o_mem_data_wr  out  DATA_W  write data
- o_load_to_accumulator_valid  out  1  accumulator load pulse
- o_load_to_accumulator_data  out  DATA_W  accumulator load value
- o_alu_control  out  3  ALU operation code
- o_alu_load  out  1  ALU operand pulse
- o_alu_data  out  DATA_W  ALU operand
- i_current_accum_value  in  DATA_W  live accumulator
- o_illegal_opcode  out  1  undefined opcode pulse

## Operation
- Accept: i_instruction_valid && o_instruction_ready at a rising edge. Call that cycle A.
- All outputs are registered. Every pulse lasts exactly one cycle. Every data and address bus is 0 whenever its strobe is low, except o_alu_control, which holds its last value.
- FSM states:
  - S_IDLE: ready=1.
  - S_RD_ISSUE: o_mem_rd high.
  - S_RD_WAIT: RD_LATENCY cycles; data is captured on the last one.
  - S_RESULT: ready=0; accumulator/ALU pulse.
- Decode, per opcode:
  - NOP: no output.
  - JUMP: target=operand.
  - JZ: jump pulse only if i_current_accum_value==0, sampled in cycle A.
  - UNLOAD: o_mem_wr, address=operand, data=i_current_accum_value sampled in cycle A.
  - ADD/SUB: o_alu_load with o_alu_data = operand resized to DATA_W (zero-extend, or truncate upper bits). o_alu_control = 3'b001 for ADD, 3'b010 for SUB.
  - LOAD: memory read, then o_load_to_accumulator_valid with the captured data.
  - ADDM/SUBM: memory read, then o_alu_load with the captured data and the ADD/SUB control code.
  - Any other opcode: o_illegal_opcode pulse; otherwise treated as NOP.
- Transitions:
  - NOP/JUMP/JZ/UNLOAD/illegal stay in S_IDLE.
  - ADD/SUB go S_IDLE→S_RESULT→S_IDLE.
  - LOAD/ADDM/SUBM go S_IDLE→S_RD_ISSUE→S_RD_WAIT→S_RESULT→S_IDLE.
- S_RESULT exists so the accumulator register is updated before the next UNLOAD or JZ samples it. There is no other hazard logic.
- i_instruction is ignored while ready=0. The fetch unit holds the instruction.

## Timing
- Reset (async assert): state=S_IDLE, wait counter=0, every output 0, o_instruction_ready=0. Ready rises at the first rising edge after deassert.
- Reset mid-operation aborts the instruction. No read result is emitted, even if i_mem_data_rd arrives later.
- Single-cycle ops (NOP/JUMP/JZ/UNLOAD/illegal): output pulse in cycle A+1. Ready stays 1, so back-to-back acceptance is allowed.
- ADD/SUB: pulse in A+1, ready=0 in A+1, next accept possible in A+2.
- Memory ops:
  - o_mem_rd in A+1.
  - Data sampled at the end of cycle A+1+RD_LATENCY.
  - Result pulse and ready=0 in A+2+RD_LATENCY.
  - Ready=1 again in A+3+RD_LATENCY.
  - Ready is low from A+1 through A+2+RD_LATENCY.
- The wait counter is ceil(log2(RD_LATENCY+1)) bits. It loads RD_LATENCY in S_RD_ISSUE, decrements in S_RD_WAIT and exits at 1.

## Structure
- Shared package / opcodes_def header holds:
  - all opcode constants, with new JZ, ADDM, SUBM and NOP=0 added there;
  - ALU codes ALU_ADD=3'b001, ALU_SUB=3'b010;
  - state encodings.
- One sub-module, param_controller_rd_seq: S_RD_ISSUE/S_RD_WAIT, the latency counter and data capture. Interface: start, address, done pulse, captured data.

## Test plan
- Reset: hold i_reset_n=0 with valid=1 and JUMP 0x20. → All outputs 0, no jump, ready rises one edge after release.
- Back-to-back: JUMP 0x3C then UNLOAD 0x10 with accum=0xA5 → jump pulse value 0x3C in A+1; o_mem_wr addr 0x10 data 0xA5 in A+2; ready never drops.
- LOAD with RD_LATENCY=1 and 3: LOAD 0x07 with memory returning 0x5A → o_mem_rd addr 0x07 in A+1; accumulator pulse data 0x5A in A+3 (latency 1) and A+5 (latency 3); ready low exactly A+1..A+2+RD_LATENCY.
- JZ: accum=0x00 with JZ 0x44 → jump to 0x44. Accum=0x01 → no pulse.
- ADDM/SUB: ADDM 0x02 with mem=0x11 → o_alu_load data 0x11, control 001. SUB 0xFF at DATA_W=16 → data 0x00FF, control 010.
- Illegal and reset abort: undefined opcode → o_illegal_opcode pulse only. Reset asserted in S_RD_WAIT → no accumulator pulse; ready returns after release.
